// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative multiplier.
// XZR is also used by the register file.
package mul_pkg;

  localparam int MUL_N = 64;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    UMULH  = 2'd1,
    SMULH  = 2'd2,
    RSVD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1) unsigned
  function automatic logic [MUL_N-1:0] abs_n(
    input logic [MUL_N-1:0] x
  );
    return x[MUL_N-1] ? (~x + MUL_N'(1)) : x;
  endfunction

  function automatic logic [2*MUL_N-1:0] neg_2n(
    input logic [2*MUL_N-1:0] x
  );
    return ~x + (2*MUL_N)'(1);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier: MUL, UMULH, SMULH.
// Start/done handshake; result drives the register-file write port.
module mul_unit
  import mul_pkg::*;
#(
  parameter int         N        = MUL_N,
  parameter logic [4:0] XZR_ADDR = XZR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   dst,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [4:0]   wa,
  output logic         we
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_acc;
  logic [N-1:0]     r_mcand;
  logic [N-1:0]     r_mplier;
  logic             r_neg;
  op_t              r_op;
  logic [4:0]       r_dst;
  logic [N-1:0]     r_result;
  logic [4:0]       r_wa;

  logic             w_accept;
  logic             w_is_s;
  logic [N:0]       w_sum;
  logic [2*N-1:0]   w_acc_nx;
  logic [2*N-1:0]   w_prod;

  assign w_accept = start & ready;
  assign w_is_s   = (op_t'(op) == SMULH);

  assign w_sum = {1'b0, r_acc[2*N-1:N]}
               + {1'b0, (r_mplier[0] ? r_mcand : '0)};
  assign w_acc_nx = {w_sum, r_acc[N-1:1]};
  assign w_prod   = r_neg ? neg_2n(w_acc_nx) : w_acc_nx;

  assign result = r_result;
  assign wa     = r_wa;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready = 1'b1;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (1'b1)
      (r_state == RUN):  begin ready = 1'b0; busy = 1'b1; end
      (r_state == DONE): done = 1'b1;
      default:           ;
    endcase
    we = done & (r_wa != XZR_ADDR);
  end

  // Operand capture, shift-add iteration, final result load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_op     <= MUL_LO;
      r_dst    <= '0;
      r_result <= '0;
      r_wa     <= '0;
    end else if (w_accept) begin
      r_op     <= op_t'(op);
      r_dst    <= dst;
      r_mcand  <= w_is_s ? abs_n(a) : a;
      r_mplier <= w_is_s ? abs_n(b) : b;
      r_neg    <= w_is_s & (a[N-1] ^ b[N-1]);
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_nx;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST) begin
        r_result <= (r_op == UMULH || r_op == SMULH)
                  ? w_prod[2*N-1:N] : w_prod[N-1:0];
        r_wa     <= r_dst;
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit.
// Each task drives one scenario and checks its own results.
module tb_mul_unit;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_UH  = 2'd1;
  localparam logic [1:0] OP_SH  = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [4:0]  dst = '0;
  logic        ready, busy, done, we;
  logic [63:0] result;
  logic [4:0]  wa;

  int vec = 0;
  int err = 0;

  mul_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .dst(dst), .ready(ready), .busy(busy),
    .done(done), .result(result), .wa(wa), .we(we)
  );

  always #5 clk = ~clk;

  // Drive one request from a post-edge point; return at done cycle
  task automatic run_op(
    input  logic [63:0] ia, input logic [63:0] ib,
    input  logic [1:0]  iop, input logic [4:0] idst,
    output logic [63:0] res, output logic rwe,
    output logic [4:0]  rwa, output int lat, output int bcnt
  );
    a = ia; b = ib; op = iop; dst = idst; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = '1; b = '1; op = 2'd3; dst = 5'd9;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result; rwe = we; rwa = wa;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({result, wa, done, we, busy, ready} !==
        {64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      err++;
      $display("FAIL reset: res=%h wa=%0d d=%b we=%b bz=%b rdy=%b",
               result, wa, done, we, busy, ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_basic;
    logic [63:0] r; logic w; logic [4:0] x; int l, bc;
    run_op(64'd3, 64'd5, OP_MUL, 5'd2, r, w, x, l, bc);
    vec++;
    if (l !== 64) begin
      err++; $display("FAIL mul_lat: got %0d want 64", l);
    end
    vec++;
    if (r !== 64'd15) begin
      err++; $display("FAIL mul_res: got %h want 15", r);
    end
    vec++;
    if (x !== 5'd2 || w !== 1'b1) begin
      err++; $display("FAIL mul_wr: wa=%0d we=%b want 2/1", x, w);
    end
    vec++;
    if (bc !== 64) begin
      err++; $display("FAIL mul_busy: got %0d want 64", bc);
    end
    @(posedge clk); #1;
    vec++;
    if (done !== 1'b0 || we !== 1'b0 || ready !== 1'b1) begin
      err++;
      $display("FAIL mul_pulse: d=%b we=%b rdy=%b want 0/0/1",
               done, we, ready);
    end
  endtask

  task automatic test_umulh;
    logic [63:0] r; logic w; logic [4:0] x; int l, bc;
    run_op('1, '1, OP_UH, 5'd3, r, w, x, l, bc);
    vec++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || l !== 64) begin
      err++; $display("FAIL umulh: got %h lat %0d", r, l);
    end
    @(posedge clk); #1;
    run_op('1, '1, OP_MUL, 5'd3, r, w, x, l, bc);
    vec++;
    if (r !== 64'd1) begin
      err++; $display("FAIL mul_wrap: got %h want 1", r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_smulh;
    logic [63:0] r; logic w; logic [4:0] x; int l, bc;
    run_op('1, 64'd1, OP_SH, 5'd4, r, w, x, l, bc);
    vec++;
    if (r !== '1) begin
      err++; $display("FAIL smulh_m1x1: got %h want all ones", r);
    end
    @(posedge clk); #1;
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           OP_SH, 5'd4, r, w, x, l, bc);
    vec++;
    if (r !== 64'h4000_0000_0000_0000) begin
      err++; $display("FAIL smulh_min: got %h want 4000..0", r);
    end
    @(posedge clk); #1;
    run_op(-64'sd3, 64'd7, OP_SH, 5'd4, r, w, x, l, bc);
    vec++;
    if (r !== '1) begin
      err++; $display("FAIL smulh_m3x7: got %h want all ones", r);
    end
    @(posedge clk); #1;
    run_op(-64'sd3, -64'sd7, OP_SH, 5'd4, r, w, x, l, bc);
    vec++;
    if (r !== 64'd0) begin
      err++; $display("FAIL smulh_m3xm7: got %h want 0", r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xzr;
    logic [63:0] r; logic w; logic [4:0] x; int l, bc;
    run_op(64'd6, 64'd7, OP_MUL, 5'd31, r, w, x, l, bc);
    vec++;
    if (done !== 1'b1 || w !== 1'b0 || r !== 64'd42) begin
      err++;
      $display("FAIL xzr: d=%b we=%b res=%0d want 1/0/42",
               done, w, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start;
    int lat;
    a = 64'd3; b = 64'd5; op = OP_MUL; dst = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        start = 1'b1; a = 64'd99; b = 64'd99; dst = 5'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    vec++;
    if (lat !== 64 || result !== 64'd15 || wa !== 5'd4) begin
      err++;
      $display("FAIL ign_start: lat=%0d res=%0d wa=%0d want 64/15/4",
               lat, result, wa);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] r; logic w; logic [4:0] x; int l, bc;
    run_op(64'd2, 64'd3, OP_MUL, 5'd5, r, w, x, l, bc);
    vec++;
    if (r !== 64'd6 || w !== 1'b1 || x !== 5'd5) begin
      err++;
      $display("FAIL b2b_first: res=%0d we=%b wa=%0d want 6/1/5",
               r, w, x);
    end
    run_op(64'd7, 64'd6, OP_MUL, 5'd6, r, w, x, l, bc);
    vec++;
    if (r !== 64'd42 || l !== 64 || x !== 5'd6) begin
      err++;
      $display("FAIL b2b_second: res=%0d lat=%0d wa=%0d want 42/64/6",
               r, l, x);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; logic w; logic [4:0] x; int l, bc, nd;
    a = 64'd9; b = 64'd9; op = OP_MUL; dst = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    vec++;
    if ({result, wa, done, we, busy, ready} !==
        {64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      err++;
      $display("FAIL rst_mid: res=%h wa=%0d d=%b bz=%b rdy=%b",
               result, wa, done, busy, ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    vec++;
    if (nd !== 0) begin
      err++; $display("FAIL rst_nodone: got %0d pulses want 0", nd);
    end
    run_op(64'd4, 64'd4, OP_MUL, 5'd1, r, w, x, l, bc);
    vec++;
    if (r !== 64'd16 || l !== 64) begin
      err++; $display("FAIL rst_after: res=%0d lat=%0d want 16/64", r, l);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_mul_basic;
    test_umulh;
    test_smulh;
    test_xzr;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative 64-bit integer multiplier on the execute side of the datapath.
- Consumes the two register-file read operands and returns a 64-bit result with write address and write enable, which drive the register-file write port.
- Implements LEGv8 MUL (low 64 bits), UMULH and SMULH (high 64 bits) with a radix-2 shift-add loop.
- Uses a start/done handshake so the control unit can stall while the unit is busy.

Parameters:
- N, 64, operand and result width; iteration count equals N.
- XZR_ADDR, 31, register address whose writes are suppressed.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled at rising clk edge, accepted only when ready=1
- op  in  2  operation: 00 MUL, 01 UMULH, 10 SMULH, 11 reserved (executed as MUL)
- a  in  N  first operand (rd1)
- b  in  N  second operand (rd2)
- dst  in  5  destination register address
- ready  out  1  unit can accept start this cycle
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse, result valid
- result  out  N  product word; held until the next accepted start or reset
- wa  out  5  write address to register file; equals captured dst
- we  out  1  write enable to register file; equals done AND (wa != XZR_ADDR)

Behaviour:
- Reset is asynchronous and active-high.
  - On assertion: state=IDLE; result=0, wa=0, done=0, we=0, busy=0, ready=1; all internal registers cleared.
  - Reset mid-operation discards the in-flight operation; no done pulse is produced.
- States:
  - IDLE: ready=1, busy=0.
  - RUN: ready=0, busy=1.
  - DONE: ready=1, busy=0, done=1.
- Transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE when the iteration counter reaches N-1.
  - DONE -> RUN on start, else DONE -> IDLE.
- Accept (start=1 and ready=1, edge E0), capture:
  - op and dst.
  - Multiplicand and multiplier magnitudes: for SMULH use two's-complement absolute values, else raw operands.
  - Negate flag = SMULH AND (a[N-1] XOR b[N-1]).
  - Clear the 2N-bit accumulator; counter=0.
- RUN, each edge:
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator (N+1-bit sum including carry).
  - Shift the accumulator and carry right one bit; shift the multiplier right; counter+1.
  - After N iterations the accumulator holds the full 2N-bit unsigned product.
- RUN -> DONE edge (edge EN):
  - Apply the negate flag as a 2N-bit two's-complement negation.
  - Load result with the low half for MUL/reserved, the high half for UMULH/SMULH.
  - Load wa=dst.
- Latency: done is high in the cycle following edge EN, N cycles after the accepting edge. done lasts exactly one cycle.
- start while busy=1 is ignored; nothing is queued or captured.
- Back-to-back: start during DONE is accepted; the current done/we pulse still completes that cycle.
- dst == XZR_ADDR: the operation executes and done pulses, but we stays 0.
- Operands are sampled only at the accepting edge; changes on a/b/op/dst afterwards have no effect.
- The SMULH magnitude of -2^(N-1) is 2^(N-1); it is represented unsigned in N bits, so no overflow.

Decomposition:
- Shared package mul_pkg:
  - op_t enum: MUL_LO, UMULH, SMULH, RSVD.
  - state_t enum: IDLE, RUN, DONE.
  - XZR constant = 5'd31, shared with the register file.
- No sub-module is needed. A combinational helper function for N-bit absolute value and 2N-bit negation belongs in mul_pkg.

Test Plan:
- Basic MUL: a=3, b=5, op=MUL, dst=2 -> done exactly 64 cycles after the accept edge; result=15, wa=2, we=1 for one cycle; busy high for the 64 RUN cycles.
- UMULH wrap: a=b=0xFFFF_FFFF_FFFF_FFFF, op=UMULH -> result=0xFFFF_FFFF_FFFF_FFFE. Same operands with op=MUL -> result=1.
- SMULH signs:
  - a=-1, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
  - a=b=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000.
  - a=-3, b=7 -> result=all ones.
- XZR and ignored start:
  - dst=31 -> done=1 with we=0.
  - start pulsed at RUN cycle 10 with different operands -> ignored; the original result is returned at the original cycle.
- Back-to-back: second start in the DONE cycle (7*6 after 2*3) -> first done gives result=6; second done follows 64 cycles later with result=42.
- Reset mid-op: assert reset at RUN cycle 30 -> outputs immediately 0, ready=1; no done pulse. A new 4*4 afterwards gives result=16.
